benes_feeder: RTL and testbench

Upstream stage of the Benes distribution network. Buffers switch configuration words (mux select bits plus a repeat count) and pairs each incoming data vector with the active configuration. Emits a registered, cycle-aligned {data, mux} pair to the Benes inputs. Lets the controller preload routing patterns and stream data without retiming mux bits against data.

---
 rtl/benes_feeder.sv | 185 ++++++++++++++++++
 tb/tb_benes_feeder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/benes_feeder.sv
// benes_feeder
// Upstream stage of the Benes distribution network. Switch configuration
// words (mux selects plus a repeat count) are queued in a small FIFO. The
// head entry is promoted to an active register, and each accepted data
// vector is paired with that active mux word. The pair is presented as a
// registered, cycle-aligned {data, mux} output, so the controller never has
// to retime mux bits against data.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   i_cfg_valid   config write request; o_cfg_ready = FIFO not full
//   i_cfg_mux     mux select word to queue
//   i_cfg_repeat  number of data vectors using the config (0 acts as 1)
//   i_data_valid  data vector offered; o_data_ready = active config held
//   i_data_bus    data vector
//   i_flush       synchronous flush of FIFO and active config
//   o_data_bus    registered data to the Benes network
//   o_mux_bus     registered mux word aligned with o_data_bus
//   o_valid       output pair is new this cycle
//   o_cfg_count   FIFO occupancy, excluding the active entry
module benes_feeder #(
    parameter int DATA_TYPE = 16,
    parameter int NUM_PES   = 8,
    parameter int LEVELS    = 7,
    parameter int MUX_W     = 2*(LEVELS-2)*NUM_PES+NUM_PES,
    parameter int CFG_DEPTH = 4,
    parameter int RPT_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_cfg_valid,
    output logic                          o_cfg_ready,
    input  logic [MUX_W-1:0]              i_cfg_mux,
    input  logic [RPT_W-1:0]              i_cfg_repeat,
    input  logic                          i_data_valid,
    output logic                          o_data_ready,
    input  logic [NUM_PES*DATA_TYPE-1:0]  i_data_bus,
    input  logic                          i_flush,
    output logic [NUM_PES*DATA_TYPE-1:0]  o_data_bus,
    output logic [MUX_W-1:0]              o_mux_bus,
    output logic                          o_valid,
    output logic [$clog2(CFG_DEPTH):0]    o_cfg_count
);

    localparam int PTR_W  = $clog2(CFG_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int DATA_W = NUM_PES * DATA_TYPE;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CFG_DEPTH);
    localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // A repeat count of zero is treated as a single use.
    function automatic logic [RPT_W-1:0] norm_repeat(input logic [RPT_W-1:0] rpt);
        return (rpt == '0) ? RPT_ONE : rpt;
    endfunction

    logic [MUX_W-1:0]  mux_mem_r [CFG_DEPTH];
    logic [RPT_W-1:0]  rpt_mem_r [CFG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    state_t            state_r;
    logic [RPT_W-1:0]  rem_r;
    logic [MUX_W-1:0]  active_mux_r;
    logic [DATA_W-1:0] data_out_r;
    logic [MUX_W-1:0]  mux_out_r;
    logic              valid_r;

    logic full_s;
    logic empty_s;
    logic fire_s;
    logic push_s;
    logic pop_s;

    // Handshake decode: the head is popped whenever the active slot is free
    // (IDLE) or is being released by the last fire of its repeat count.
    always_comb begin
        full_s  = (count_r == FULL_CNT);
        empty_s = (count_r == '0);
        fire_s  = i_data_valid & (state_r == ST_ACTIVE);
        push_s  = i_cfg_valid & ~full_s;
        pop_s   = 1'b0;
        if (state_r == ST_IDLE) begin
            pop_s = ~empty_s;
        end else begin
            pop_s = fire_s & (rem_r == RPT_ONE) & ~empty_s;
        end
    end

    // Configuration FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < CFG_DEPTH; i++) begin
                mux_mem_r[i] <= '0;
                rpt_mem_r[i] <= '0;
            end
        end else if (i_flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                mux_mem_r[wr_ptr_r] <= i_cfg_mux;
                rpt_mem_r[wr_ptr_r] <= i_cfg_repeat;
                wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Active-config FSM and the registered {data, mux} output pair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            rem_r        <= '0;
            active_mux_r <= '0;
            data_out_r   <= '0;
            mux_out_r    <= '0;
            valid_r      <= 1'b0;
        end else if (i_flush) begin
            // Outputs hold; only the valid strobe and the active slot clear.
            state_r <= ST_IDLE;
            rem_r   <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= fire_s;
            if (fire_s) begin
                data_out_r <= i_data_bus;
                mux_out_r  <= active_mux_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        active_mux_r <= mux_mem_r[rd_ptr_r];
                        rem_r        <= norm_repeat(rpt_mem_r[rd_ptr_r]);
                        state_r      <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (fire_s) begin
                        if (rem_r == RPT_ONE) begin
                            if (pop_s) begin
                                // Back-to-back reload keeps o_data_ready high.
                                active_mux_r <= mux_mem_r[rd_ptr_r];
                                rem_r        <= norm_repeat(rpt_mem_r[rd_ptr_r]);
                            end else begin
                                rem_r   <= '0;
                                state_r <= ST_IDLE;
                            end
                        end else begin
                            rem_r <= rem_r - RPT_ONE;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    rem_r   <= '0;
                end
            endcase
        end
    end

    assign o_cfg_ready  = ~full_s;
    assign o_data_ready = (state_r == ST_ACTIVE);
    assign o_data_bus   = data_out_r;
    assign o_mux_bus    = mux_out_r;
    assign o_valid      = valid_r;
    assign o_cfg_count  = count_r;

endmodule

// File: tb/tb_benes_feeder.sv
// Testbench for benes_feeder: table-driven single-config scenarios plus
// hand-written sequences (seamless switch, FIFO full, flush, async reset).
// Data/mux pairs are checked through a scoreboard queue filled on each fire.
module tb_benes_feeder;

    localparam int DW = 128;
    localparam int MW = 88;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_cfg_valid;
    logic          o_cfg_ready;
    logic [MW-1:0] i_cfg_mux;
    logic [7:0]    i_cfg_repeat;
    logic          i_data_valid;
    logic          o_data_ready;
    logic [DW-1:0] i_data_bus;
    logic          i_flush;
    logic [DW-1:0] o_data_bus;
    logic [MW-1:0] o_mux_bus;
    logic          o_valid;
    logic [2:0]    o_cfg_count;

    benes_feeder dut (
        .clk(clk), .rst(rst),
        .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
        .i_cfg_mux(i_cfg_mux), .i_cfg_repeat(i_cfg_repeat),
        .i_data_valid(i_data_valid), .o_data_ready(o_data_ready),
        .i_data_bus(i_data_bus), .i_flush(i_flush),
        .o_data_bus(o_data_bus), .o_mux_bus(o_mux_bus),
        .o_valid(o_valid), .o_cfg_count(o_cfg_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [MW-1:0] mux;
    } sb_t;

    typedef struct {
        logic [MW-1:0] mux;
        logic [7:0]    rpt;
        int            nvec;
        int            nfire;
        logic [DW-1:0] data;
    } vec_t;

    sb_t           sb[$];
    logic [MW-1:0] exp_mux_v;
    int            checks = 0;
    int            errors = 0;

    localparam logic [MW-1:0] MUX_ONES = 88'hFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [MW-1:0] MUX_B    = 88'hFF_0000_0000_0000_0000_0000;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_cfg(input logic [MW-1:0] mux, input logic [7:0] rpt);
        i_cfg_valid  = 1'b1;
        i_cfg_mux    = mux;
        i_cfg_repeat = rpt;
        step();
        i_cfg_valid  = 1'b0;
    endtask

    // Scoreboard: compare outputs produced by the previous fire, then record
    // the fire (if any) that the coming edge will accept.
    always @(negedge clk) begin
        if (rst) begin
            if (o_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_valid actual=1 expected=0");
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("sb_data", o_data_bus, e.data);
                    chk("sb_mux", {40'h0, o_mux_bus}, {40'h0, e.mux});
                end
            end
            if (i_data_valid && o_data_ready && !i_flush) begin
                sb.push_back('{data: i_data_bus, mux: exp_mux_v});
            end
        end
    end

    vec_t        tbl[4];
    logic [MW-1:0] cm[6];
    int          exp_cnt[6];

    initial begin
        tbl[0] = '{mux: MUX_ONES, rpt: 8'd1, nvec: 2, nfire: 1,
                   data: 128'h7777_6666_5555_4444_3333_2222_1111_0000};
        tbl[1] = '{mux: 88'h0, rpt: 8'd3, nvec: 4, nfire: 3,
                   data: 128'hA000_0000_0000_0000_0000_0000_0000_0010};
        tbl[2] = '{mux: 88'h12_3456_789A_BCDE_F012_3456, rpt: 8'd0, nvec: 2, nfire: 1,
                   data: 128'hB000_0000_0000_0000_0000_0000_0000_0020};
        tbl[3] = '{mux: 88'h55_AAAA_5555_AAAA_5555_AAAA, rpt: 8'd2, nvec: 3, nfire: 2,
                   data: 128'hC000_0000_0000_0000_0000_0000_0000_0030};
        for (int i = 0; i < 6; i++) cm[i] = {11{8'(i + 1)}};
        exp_cnt = '{3, 3, 2, 1, 0, 0};

        rst = 1'b0; i_cfg_valid = 1'b0; i_cfg_mux = '0; i_cfg_repeat = '0;
        i_data_valid = 1'b0; i_data_bus = '0; i_flush = 1'b0; exp_mux_v = '0;

        #3;
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data_bus, 0);
        chk("rst_mux", o_mux_bus, 0);
        chk("rst_count", o_cfg_count, 0);
        chk("rst_dready", o_data_ready, 0);
        chk("rst_cready", o_cfg_ready, 1);
        #10 rst = 1'b1;
        step();

        // Table: one config, then a burst of back-to-back vectors.
        for (int e = 0; e < 4; e++) begin
            wr_cfg(tbl[e].mux, tbl[e].rpt);
            chk("tbl_ready_t1", o_data_ready, 0);
            step();
            chk("tbl_ready_t2", o_data_ready, 1);
            for (int k = 0; k < tbl[e].nvec; k++) begin
                i_data_valid = 1'b1;
                i_data_bus   = tbl[e].data + 128'(k);
                exp_mux_v    = tbl[e].mux;
                chk("tbl_stream_ready", o_data_ready, (k < tbl[e].nfire));
                chk("tbl_stream_valid", o_valid, (k > 0 && k - 1 < tbl[e].nfire));
                step();
            end
            i_data_valid = 1'b0;
            chk("tbl_tail_valid", o_valid, (tbl[e].nvec - 1 < tbl[e].nfire));
            chk("tbl_tail_ready", o_data_ready, 0);
            step();
            chk("tbl_idle_valid", o_valid, 0);
        end

        // Seamless switch A(2) -> B(1) with no bubble.
        wr_cfg(MUX_ONES, 8'd2);
        wr_cfg(MUX_B, 8'd1);
        chk("sw_ready", o_data_ready, 1);
        chk("sw_count", o_cfg_count, 1);
        for (int k = 0; k < 3; k++) begin
            i_data_valid = 1'b1;
            i_data_bus   = 128'hD000 + 128'(k);
            exp_mux_v    = (k < 2) ? MUX_ONES : MUX_B;
            chk("sw_stream_ready", o_data_ready, 1);
            chk("sw_stream_valid", o_valid, (k > 0));
            step();
        end
        i_data_valid = 1'b0;
        chk("sw_last_valid", o_valid, 1);
        chk("sw_end_ready", o_data_ready, 0);
        chk("sw_end_count", o_cfg_count, 0);
        step();

        // FIFO full: five writes while IDLE, then a blocked write.
        for (int i = 0; i < 5; i++) begin
            i_cfg_valid = 1'b1; i_cfg_mux = cm[i]; i_cfg_repeat = 8'd1;
            step();
        end
        i_cfg_mux = cm[5];
        chk("full_count", o_cfg_count, 4);
        chk("full_cready", o_cfg_ready, 0);
        step();
        i_cfg_valid = 1'b0;
        chk("full_blocked_count", o_cfg_count, 4);
        // Drain: fire 0 pops with a blocked push, fire 1 pushes and pops.
        for (int k = 0; k < 6; k++) begin
            i_data_valid = 1'b1;
            i_data_bus   = 128'hE000 + 128'(k);
            exp_mux_v    = cm[k];
            i_cfg_valid  = (k < 2);
            i_cfg_mux    = cm[5];
            chk("full_stream_ready", o_data_ready, 1);
            step();
            chk("full_drain_count", o_cfg_count, 128'(exp_cnt[k]));
        end
        i_data_valid = 1'b0; i_cfg_valid = 1'b0;
        chk("full_end_ready", o_data_ready, 0);
        step();

        // Flush after 1 of 3 repeats; the flush-cycle write and fire are dropped.
        wr_cfg(88'h0F_0F0F_0F0F_0F0F_0F0F_0F0F, 8'd3);
        wr_cfg(88'h33_3333_3333_3333_3333_3333, 8'd1);
        i_data_valid = 1'b1; i_data_bus = 128'hF00D_0001;
        exp_mux_v = 88'h0F_0F0F_0F0F_0F0F_0F0F_0F0F;
        step();
        i_data_valid = 1'b0;
        chk("fl_pre_valid", o_valid, 1);
        i_flush = 1'b1; i_data_valid = 1'b1; i_data_bus = 128'hBAD0_0002;
        i_cfg_valid = 1'b1; i_cfg_mux = 88'h44; i_cfg_repeat = 8'd1;
        step();
        i_flush = 1'b0; i_data_valid = 1'b0; i_cfg_valid = 1'b0;
        chk("fl_dready", o_data_ready, 0);
        chk("fl_count", o_cfg_count, 0);
        chk("fl_valid", o_valid, 0);
        chk("fl_hold_data", o_data_bus, 128'hF00D_0001);
        chk("fl_hold_mux", {40'h0, o_mux_bus}, {40'h0, 88'h0F_0F0F_0F0F_0F0F_0F0F_0F0F});
        step();
        chk("fl_stay_idle", o_data_ready, 0);
        chk("fl_stay_valid", o_valid, 0);

        // Asynchronous reset mid-stream.
        wr_cfg(88'h66_6666_6666_6666_6666_6666, 8'd2);
        wr_cfg(88'h77_7777_7777_7777_7777_7777, 8'd1);
        i_data_valid = 1'b1; i_data_bus = 128'hCAFE_0003;
        exp_mux_v = 88'h66_6666_6666_6666_6666_6666;
        step();
        i_data_valid = 1'b0;
        step();
        chk("ar_pre_data", o_data_bus, 128'hCAFE_0003);
        chk("ar_pre_count", o_cfg_count, 1);
        #2 rst = 1'b0;
        #1;
        chk("ar_data", o_data_bus, 0);
        chk("ar_mux", {40'h0, o_mux_bus}, 0);
        chk("ar_valid", o_valid, 0);
        chk("ar_dready", o_data_ready, 0);
        chk("ar_count", o_cfg_count, 0);
        chk("ar_cready", o_cfg_ready, 1);
        #3 rst = 1'b1;
        step();
        chk("ar_post_ready", o_data_ready, 0);
        step();
        chk("ar_post_ready2", o_data_ready, 0);

        chk("sb_empty", 128'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
